color_i2c_target: RTL and testbench
===================================

# color_i2c_target

Synthesizable I2C target that emulates the Pmod COLOR sensor's register map, which makes it the responder end of the Pmod COLOR host interface. It decodes START and STOP conditions, matches the 7-bit chip address, and handles command bytes: single or auto-increment register access. Writes update the ENABLE, ATIME and CONTROL registers. Reads return ID, STATUS and the 16-bit clear/red/green/blue channel data supplied by the fabric. It serves as a loopback target for host-side benches and as a sensor stand-in on boards without the Pmod fitted.

## Interface
- CHIPADDRS, 7'h29, 7-bit target address.
- ID_VALUE, 8'h44, value returned from register 0x12.
- clk  input  1  system clock; must run at least 16x SCL frequency.
- rst  input  1  synchronous, active-low reset.
- SCL  input  1  I2C clock from host (target never stretches).
- SDA  inout  1  open-drain; driven 1'b0 or 1'bZ only.
- clear, red, green, blue  input  16 each  channel data from fabric.
- data_valid  input  1  one-clk pulse: channel inputs hold a new sample.
- pon  output  1  ENABLE[0]; reset 0.
- aen  output  1  ENABLE[1]; reset 0.
- gain  output  2  CONTROL[1:0]; reset 2'b00.
- atime  output  8  ATIME register; reset 8'hFF.
- cfg_wr  output  1  one-clk pulse after any register write ACK; reset 0.
- busy  output  1  high from an address-matched START until STOP; reset 0.

## Operation
- Front end: SCL and SDA pass through 2-FF synchronizers. START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- Bit timing:
  - Bits are sampled on a synchronized SCL rising edge, MSB first.
  - The target changes SDA only on the clk after a synchronized SCL falling edge.
- States:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits, then go to ADDR_ACK if the address matches, otherwise to IDLE and ignore bits until the next START.
  - ADDR_ACK: drive 0 for one SCL period. Then go to CMD if R/W=0, or to RDATA if R/W=1.
  - CMD: shift 8 bits, then go to CMD_ACK.
    - Bit 7 = 1: the command is valid and is ACKed.
    - Bit 7 = 0: the byte is NACKed, SDA is released, and the FSM waits for START/STOP.
    - Command fields: bits 6:5 type (00 repeated, 01 auto-increment), bits 4:0 register pointer.
  - CMD_ACK -> WDATA.
  - WDATA: shift 8 bits, then go to WDATA_ACK.
    - Always ACK.
    - Write the byte to the pointer; then, if type=01, increment the pointer.
    - Return to WDATA.
  - RDATA:
    - Load the byte at the pointer and shift it out; then, if type=01, increment the pointer.
    - Then go to MACK.
  - MACK: sample the host bit. 0 -> RDATA. 1 -> release SDA and wait for STOP.
- START or STOP detected in any state aborts the current byte, releases SDA and enters ADDR (START) or IDLE (STOP). This holds for a repeated START mid-byte.
- Register map:
  - Writable: 0x00 ENABLE (bits 1:0), 0x01 ATIME, 0x0F CONTROL (bits 1:0).
  - Read-only: 0x12 ID, 0x13 STATUS (bit 0 AVALID).
  - Read-only data, little-endian pairs: 0x14 C, 0x16 R, 0x18 G, 0x1A B.
  - Writes to read-only or unmapped addresses are ACKed and discarded. Unmapped reads return 8'h00.
- The pointer is 5 bits and wraps 0x1F -> 0x00.
- AVALID:
  - Set on data_valid while aen=1.
  - Cleared when aen is written to 0 or by reset.
  - Simultaneous data_valid and an aen-clearing write: clear wins.
- The command type field persists across a repeated START, so a write-pointer-then-read sequence works.

## Timing
- START/STOP detection latency: 3 clk from pin edge (2 sync + 1 edge register).
- ACK drive:
  - SDA goes low within 2 clk of the SCL falling edge that ends bit 8.
  - It is released within 2 clk of the following SCL falling edge.
- Read data setup: the first bit is on SDA within 2 clk of the SCL falling edge after the ACK.
- cfg_wr pulses exactly one clk, on the clk in which the register updates (at the WDATA_ACK entry).
- Reset mid-transfer: SDA released the same cycle rst is sampled low. All registers return to reset values and the FSM goes to IDLE.

## Configuration
- COLOR_TARGET_SHADOW_EN:
  - Defined: all four channels are copied into a 64-bit shadow on each ADDR_ACK with R/W=1. Reads serve the shadow, so a multi-byte burst is coherent even if data_valid arrives mid-read.
  - Undefined: reads sample the live channel inputs when each byte is loaded, and no shadow registers exist.

## Structure
- Package color_pkg: register address constants (ENABLE, ATIME, CONTROL, ID, STATUS, CDATAL … BDATAH), command field positions and the FSM state enum.
- One sub-module, i2c_line_sync:
  - Synchronizes SCL/SDA and outputs scl_rise, scl_fall, start_det and stop_det.
  - Instantiated once.

## Test plan
- Write 0x29/W, cmd 0x80, data 0x03 -> three ACKs, pon=1, aen=1, one cfg_wr pulse.
- Write cmd 0xAF, data 0x02 then 0x55 (auto-increment from 0x0F) -> gain=2'b10; the 0x10 write is discarded and pointer wrap is not triggered.
- Load red=16'h1234 with data_valid, aen=1; write cmd 0xB6, repeated START, 0x29/R, read 2 bytes with ACK then NACK -> 8'h34, 8'h12; the STATUS read afterwards returns 8'h01.
- Address 0x2A/W -> no ACK (SDA stays Z for the whole frame), busy stays 0, registers unchanged.
- STOP injected after bit 4 of a data byte -> FSM in IDLE within 3 clk, SDA released, no register change.
- With COLOR_TARGET_SHADOW_EN, change blue via data_valid between bytes of an 8-byte burst from 0x14 -> all bytes equal the pre-burst values.

Source files
------------

// File: rtl/color_pkg.sv
// Register map, command field positions and FSM state encoding for the Pmod COLOR I2C target.
package color_pkg;

  localparam logic [4:0] REG_ENABLE  = 5'h00;
  localparam logic [4:0] REG_ATIME   = 5'h01;
  localparam logic [4:0] REG_CONTROL = 5'h0F;
  localparam logic [4:0] REG_ID      = 5'h12;
  localparam logic [4:0] REG_STATUS  = 5'h13;
  localparam logic [4:0] REG_CDATAL  = 5'h14;
  localparam logic [4:0] REG_CDATAH  = 5'h15;
  localparam logic [4:0] REG_RDATAL  = 5'h16;
  localparam logic [4:0] REG_RDATAH  = 5'h17;
  localparam logic [4:0] REG_GDATAL  = 5'h18;
  localparam logic [4:0] REG_GDATAH  = 5'h19;
  localparam logic [4:0] REG_BDATAL  = 5'h1A;
  localparam logic [4:0] REG_BDATAH  = 5'h1B;

  localparam int CMD_VALID_BIT = 7;
  localparam int CMD_TYPE_MSB  = 6;
  localparam int CMD_TYPE_LSB  = 5;
  localparam int CMD_PTR_MSB   = 4;

  localparam logic [1:0] CMD_TYPE_REPEAT = 2'b00;
  localparam logic [1:0] CMD_TYPE_AUTO   = 2'b01;

  localparam logic [7:0] ATIME_RESET = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_CMD,
    S_CMD_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_MACK,
    S_WAIT
  } state_t;

  // Channel block is {blue, green, red, clear}, each little-endian from CDATAL upward.
  function automatic logic [7:0] chan_byte(input logic [63:0] chan, input logic [4:0] ptr);
    logic [2:0] idx;
    idx = 3'(ptr - REG_CDATAL);
    return chan[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge and START/STOP condition detection.
module i2c_line_sync
  import color_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_line,
  input  logic sda_line,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_meta;
  logic [1:0] sda_meta;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_sync;

  // Idle bus is high on both lines, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_meta <= 2'b11;
      sda_meta <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= {scl_meta[0], scl_line};
      sda_meta <= {sda_meta[0], sda_line};
      scl_prev <= scl_meta[1];
      sda_prev <= sda_meta[1];
    end
  end

  assign scl_sync  = scl_meta[1];
  assign sda_sync  = sda_meta[1];
  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

endmodule

// File: rtl/color_i2c_target.sv
// I2C target emulating the Pmod COLOR register map.
// Define COLOR_TARGET_SHADOW_EN to snapshot channel data at each read-address ACK.
//
// state       | meaning
// S_IDLE      | bus free, waiting for START
// S_ADDR      | shifting in address + R/W
// S_ADDR_ACK  | driving ACK for matched address
// S_CMD       | shifting in command byte
// S_CMD_ACK   | driving ACK for valid command
// S_WDATA     | shifting in write data
// S_WDATA_ACK | driving ACK after register write
// S_RDATA     | shifting out read data
// S_MACK      | sampling host ACK/NACK
// S_WAIT      | ignoring bus until START or STOP
module color_i2c_target
  import color_pkg::*;
#(
  parameter logic [6:0] CHIPADDRS = 7'h29,
  parameter logic [7:0] ID_VALUE  = 8'h44
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] clear,
  input  logic [15:0] red,
  input  logic [15:0] green,
  input  logic [15:0] blue,
  input  logic        data_valid,
  output logic        pon,
  output logic        aen,
  output logic [1:0]  gain,
  output logic [7:0]  atime,
  output logic        cfg_wr,
  output logic        busy
);

  state_t      state;
  state_t      state_nxt;
  logic        sda_sync;
  logic        scl_rise;
  logic        scl_fall;
  logic        start_det;
  logic        stop_det;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic [7:0]  rd_data;
  logic [4:0]  ptr;
  logic [1:0]  cmd_type;
  logic        host_nack;
  logic [1:0]  enable_reg;
  logic [1:0]  control_reg;
  logic [7:0]  atime_reg;
  logic        avalid;
  logic        sda_low;
  logic        byte_done;
  logic        addr_hit;
  logic        wr_strobe;
  logic        rd_load;
  logic        addr_ack_entry;
  logic [63:0] chan;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_line  (SCL),
    .sda_line  (SDA),
    .sda_sync  (sda_sync),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign byte_done      = scl_fall && (bit_cnt == 4'd8);
  assign addr_hit       = (rx_byte[7:1] == CHIPADDRS);
  assign wr_strobe      = (state == S_WDATA) && (state_nxt == S_WDATA_ACK);
  assign rd_load        = (state != S_RDATA) && (state_nxt == S_RDATA);
  assign addr_ack_entry = (state == S_ADDR) && (state_nxt == S_ADDR_ACK);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = S_ADDR;
    end else if (stop_det) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_ADDR:      if (byte_done) state_nxt = addr_hit ? S_ADDR_ACK : S_WAIT;
        S_ADDR_ACK:  if (scl_fall)  state_nxt = rx_byte[0] ? S_RDATA : S_CMD;
        S_CMD:       if (byte_done) state_nxt = rx_byte[CMD_VALID_BIT] ? S_CMD_ACK : S_WAIT;
        S_CMD_ACK:   if (scl_fall)  state_nxt = S_WDATA;
        S_WDATA:     if (byte_done) state_nxt = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall)  state_nxt = S_WDATA;
        S_RDATA:     if (byte_done) state_nxt = S_MACK;
        S_MACK:      if (scl_fall)  state_nxt = host_nack ? S_WAIT : S_RDATA;
        S_IDLE, S_WAIT: state_nxt = state;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sda_low = 1'b0;
    case (state)
      S_ADDR_ACK, S_CMD_ACK, S_WDATA_ACK: sda_low = 1'b1;
      S_RDATA: sda_low = ~tx_byte[7];
      default: sda_low = 1'b0;
    endcase
    pon   = enable_reg[0];
    aen   = enable_reg[1];
    gain  = control_reg;
    atime = atime_reg;
  end

  assign SDA = sda_low ? 1'b0 : 1'bz;

`ifdef COLOR_TARGET_SHADOW_EN
  logic [63:0] shadow;

  always_ff @(posedge clk) begin
    if (!rst)                               shadow <= '0;
    else if (addr_ack_entry && rx_byte[0])  shadow <= {blue, green, red, clear};
  end

  assign chan = shadow;
`else
  assign chan = {blue, green, red, clear};
`endif

  always_comb begin
    rd_data = 8'h00;
    case (ptr)
      REG_ENABLE:  rd_data = {6'b0, enable_reg};
      REG_ATIME:   rd_data = atime_reg;
      REG_CONTROL: rd_data = {6'b0, control_reg};
      REG_ID:      rd_data = ID_VALUE;
      REG_STATUS:  rd_data = {7'b0, avalid};
      REG_CDATAL, REG_CDATAH, REG_RDATAL, REG_RDATAH,
      REG_GDATAL, REG_GDATAH, REG_BDATAL, REG_BDATAH:
                   rd_data = chan_byte(chan, ptr);
      default:     rd_data = 8'h00;
    endcase
  end

  // Bit counter restarts on every phase change so each byte counts 8 SCL rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt   <= '0;
      rx_byte   <= '0;
      tx_byte   <= 8'hFF;
      host_nack <= 1'b1;
      ptr       <= '0;
      cmd_type  <= CMD_TYPE_REPEAT;
    end else begin
      if (start_det || stop_det || (state_nxt != state)) bit_cnt <= '0;
      else if (scl_rise && (bit_cnt != 4'd8))            bit_cnt <= bit_cnt + 4'd1;

      if (scl_rise && (state inside {S_ADDR, S_CMD, S_WDATA}))
        rx_byte <= {rx_byte[6:0], sda_sync};

      if (scl_rise && (state == S_MACK)) host_nack <= sda_sync;

      if (rd_load)
        tx_byte <= rd_data;
      else if ((state == S_RDATA) && scl_fall && !byte_done)
        tx_byte <= {tx_byte[6:0], 1'b1};

      if ((state == S_CMD) && (state_nxt == S_CMD_ACK)) begin
        cmd_type <= rx_byte[CMD_TYPE_MSB:CMD_TYPE_LSB];
        ptr      <= rx_byte[CMD_PTR_MSB:0];
      end else if ((wr_strobe || rd_load) && (cmd_type == CMD_TYPE_AUTO)) begin
        ptr <= ptr + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      enable_reg  <= 2'b00;
      control_reg <= 2'b00;
      atime_reg   <= ATIME_RESET;
      avalid      <= 1'b0;
      cfg_wr      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cfg_wr <= wr_strobe;
      if (wr_strobe) begin
        case (ptr)
          REG_ENABLE:  enable_reg  <= rx_byte[1:0];
          REG_ATIME:   atime_reg   <= rx_byte;
          REG_CONTROL: control_reg <= rx_byte[1:0];
          default:     ;
        endcase
      end

      // A write clearing aen beats a coincident sample strobe.
      if (wr_strobe && (ptr == REG_ENABLE) && !rx_byte[1]) avalid <= 1'b0;
      else if (data_valid && enable_reg[1])                 avalid <= 1'b1;

      if (stop_det)            busy <= 1'b0;
      else if (addr_ack_entry) busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_color_i2c_target.sv
// Scoreboard bench for color_i2c_target: directed I2C transactions, queued expectations.
module tb_color_i2c_target;

  localparam int Q = 50;

  typedef struct {
    string       name;
    logic [31:0] val;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl = 1'b1;
  logic        host_low = 1'b0;
  wire         sda;
  logic [15:0] clear = 16'h0;
  logic [15:0] red = 16'h0;
  logic [15:0] green = 16'h0;
  logic [15:0] blue = 16'h0;
  logic        data_valid = 1'b0;
  logic        pon;
  logic        aen;
  logic [1:0]  gain;
  logic [7:0]  atime;
  logic        cfg_wr;
  logic        busy;

  item_t exp_q[$];
  item_t obs_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cfg_hi = 0;
  int    z_viol = 0;
  logic  watch_z = 1'b0;

  pullup (sda);
  assign sda = host_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  color_i2c_target dut (
    .clk        (clk),
    .rst        (rst),
    .SCL        (scl),
    .SDA        (sda),
    .clear      (clear),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .data_valid (data_valid),
    .pon        (pon),
    .aen        (aen),
    .gain       (gain),
    .atime      (atime),
    .cfg_wr     (cfg_wr),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (cfg_wr === 1'b1) cfg_hi++;
    if (watch_z && !host_low && (sda !== 1'b1)) z_viol++;
  end

  initial begin : monitor
    item_t o;
    item_t e;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s: got 0x%0h, no expectation queued", o.name, o.val);
        end else begin
          e = exp_q.pop_front();
          if ((e.val !== o.val) || (e.name != o.name)) begin
            errors++;
            $display("FAIL %s: got 0x%0h (%s), expected 0x%0h", e.name, o.val, o.name, e.val);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: time limit reached, expected stimulus to complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic expect_val(input string n, input logic [31:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic observe(input string n, input logic [31:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    obs_q.push_back(it);
  endtask

  task automatic snap(input string n, input logic [31:0] e, input logic [31:0] a);
    expect_val(n, e);
    observe(n, a);
  endtask

  task automatic i2c_start();
    host_low = 1'b0; #Q;
    scl = 1'b1;      #Q;
    host_low = 1'b1; #Q;
    scl = 1'b0;      #Q;
  endtask

  task automatic i2c_stop();
    host_low = 1'b1; #Q;
    scl = 1'b1;      #Q;
    host_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    host_low = ~b; #Q;
    scl = 1'b1;    #(2*Q);
    scl = 1'b0;    #Q;
  endtask

  task automatic recv_bit(output logic b);
    host_low = 1'b0; #Q;
    scl = 1'b1;      #Q;
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    #Q;
    scl = 1'b0;      #Q;
  endtask

  task automatic write_byte(input string n, input logic [7:0] b, input logic exp_ack);
    logic a;
    expect_val(n, 32'(exp_ack));
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    observe(n, 32'(a));
  endtask

  task automatic read_byte(input string n, input logic [7:0] exp_b, input logic nack);
    logic [7:0] r;
    logic       b;
    expect_val(n, 32'(exp_b));
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      r[i] = b;
    end
    send_bit(nack);
    observe(n, 32'(r));
  endtask

  task automatic pulse_valid();
    @(negedge clk) data_valid = 1'b1;
    @(negedge clk) data_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  logic [7:0] burst_exp [8];

  initial begin : stimulus
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    snap("rst_pon", 32'd0, 32'(pon));
    snap("rst_aen", 32'd0, 32'(aen));
    snap("rst_gain", 32'd0, 32'(gain));
    snap("rst_atime", 32'hFF, 32'(atime));
    snap("rst_busy", 32'd0, 32'(busy));
    snap("rst_cfg_wr", 32'd0, 32'(cfg_wr));
    snap("rst_sda", 32'd1, 32'(sda));

    // ENABLE write: pon and aen set
    i2c_start();
    write_byte("t1_addr_ack", 8'h52, 1'b0);
    write_byte("t1_cmd_ack", 8'h80, 1'b0);
    write_byte("t1_data_ack", 8'h03, 1'b0);
    snap("t1_busy_in_frame", 32'd1, 32'(busy));
    i2c_stop();
    settle();
    snap("t1_pon", 32'd1, 32'(pon));
    snap("t1_aen", 32'd1, 32'(aen));
    snap("t1_cfg_pulses", 32'd1, 32'(cfg_hi));
    snap("t1_busy_after_stop", 32'd0, 32'(busy));

    // auto-increment from CONTROL into unmapped 0x10
    i2c_start();
    write_byte("t2_addr_ack", 8'h52, 1'b0);
    write_byte("t2_cmd_ack", 8'hAF, 1'b0);
    write_byte("t2_d0_ack", 8'h02, 1'b0);
    write_byte("t2_d1_ack", 8'h55, 1'b0);
    i2c_stop();
    settle();
    snap("t2_gain", 32'd2, 32'(gain));
    snap("t2_atime", 32'hFF, 32'(atime));
    snap("t2_pon", 32'd1, 32'(pon));
    snap("t2_cfg_pulses", 32'd3, 32'(cfg_hi));

    // pointer write, repeated START, read red little-endian
    clear = 16'hC1C0;
    red   = 16'h1234;
    green = 16'h6756;
    blue  = 16'hB1B0;
    pulse_valid();
    i2c_start();
    write_byte("t3_addr_w_ack", 8'h52, 1'b0);
    write_byte("t3_cmd_ack", 8'hB6, 1'b0);
    i2c_start();
    write_byte("t3_addr_r_ack", 8'h53, 1'b0);
    read_byte("t3_rdatal", 8'h34, 1'b0);
    read_byte("t3_rdatah", 8'h12, 1'b1);
    i2c_stop();
    i2c_start();
    write_byte("t3s_addr_w_ack", 8'h52, 1'b0);
    write_byte("t3s_cmd_ack", 8'h93, 1'b0);
    i2c_start();
    write_byte("t3s_addr_r_ack", 8'h53, 1'b0);
    read_byte("t3s_status", 8'h01, 1'b1);
    i2c_stop();
    settle();
    snap("t3_cfg_pulses", 32'd3, 32'(cfg_hi));

    // foreign address: no ACK, no drive, no busy
    watch_z = 1'b1;
    i2c_start();
    write_byte("t4_addr_nack", 8'h54, 1'b1);
    write_byte("t4_byte_nack", 8'h80, 1'b1);
    snap("t4_busy", 32'd0, 32'(busy));
    i2c_stop();
    settle();
    watch_z = 1'b0;
    snap("t4_sda_never_low", 32'd0, 32'(z_viol));
    snap("t4_pon", 32'd1, 32'(pon));
    snap("t4_cfg_pulses", 32'd3, 32'(cfg_hi));

    // STOP after 4 data bits aborts the write
    i2c_start();
    write_byte("t5_addr_ack", 8'h52, 1'b0);
    write_byte("t5_cmd_ack", 8'h81, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    i2c_stop();
    repeat (4) @(negedge clk);
    snap("t5_busy", 32'd0, 32'(busy));
    snap("t5_sda", 32'd1, 32'(sda));
    snap("t5_atime", 32'hFF, 32'(atime));
    snap("t5_cfg_pulses", 32'd3, 32'(cfg_hi));
    i2c_start();
    write_byte("t5b_addr_ack", 8'h52, 1'b0);
    write_byte("t5b_cmd_ack", 8'h81, 1'b0);
    write_byte("t5b_data_ack", 8'h5A, 1'b0);
    i2c_stop();
    settle();
    snap("t5b_atime", 32'h5A, 32'(atime));
    snap("t5b_cfg_pulses", 32'd4, 32'(cfg_hi));

    // 8-byte burst from CDATAL with blue changing mid-burst
    burst_exp[0] = 8'hC0;
    burst_exp[1] = 8'hC1;
    burst_exp[2] = 8'h34;
    burst_exp[3] = 8'h12;
    burst_exp[4] = 8'h56;
    burst_exp[5] = 8'h67;
`ifdef COLOR_TARGET_SHADOW_EN
    burst_exp[6] = 8'hB0;
    burst_exp[7] = 8'hB1;
`else
    burst_exp[6] = 8'hD0;
    burst_exp[7] = 8'hD1;
`endif
    i2c_start();
    write_byte("t6_addr_w_ack", 8'h52, 1'b0);
    write_byte("t6_cmd_ack", 8'hB4, 1'b0);
    i2c_start();
    write_byte("t6_addr_r_ack", 8'h53, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        blue = 16'hD1D0;
        pulse_valid();
      end
      read_byte($sformatf("t6_burst%0d", i), burst_exp[i], (i == 7));
    end
    i2c_stop();
    settle();

    // reset asserted while the target drives an address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h52 >> i));
    host_low = 1'b0;
    @(negedge clk);
    snap("t7_ack_driven", 32'd0, 32'(sda));
    rst = 1'b0;
    @(negedge clk);
    snap("t7_sda_released", 32'd1, 32'(sda));
    snap("t7_pon", 32'd0, 32'(pon));
    snap("t7_atime", 32'hFF, 32'(atime));
    snap("t7_gain", 32'd0, 32'(gain));
    snap("t7_busy", 32'd0, 32'(busy));
    @(negedge clk);
    rst = 1'b1;
    i2c_stop();
    settle();

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations unmatched, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
